seq_divider32: RTL and testbench

- Iterative restoring divider for 32-bit ARM UDIV/SDIV. It is the inverse datapath of the multiply-accumulate adders.
- Each iteration subtracts the divisor from a 33-bit partial remainder, instead of adding a zero-extended operand into a wide accumulator.
- Sits in the execute stage beside the multiplier. The pipeline issues through a start/busy/done handshake and stalls while busy.

---
 rtl/seq_divider32.sv | 172 +++++++++++++++++
 tb/tb_seq_divider32.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// seq_divider32: iterative restoring divider for UDIV/SDIV.
// One quotient bit per cycle through a WIDTH+1 bit trial subtraction.
// Optional signed support is enabled by defining SEQ_DIVIDER32_SIGNED_EN,
// which adds the is_signed input. The default build is unsigned only.
module seq_divider32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SEQ_DIVIDER32_SIGNED_EN
   input  logic             is_signed,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (bit WIDTH is always 0 after restore)
   logic [WIDTH-1:0] q_q, q_d;          // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             dbz_q, dbz_d;
   logic             qneg_q, qneg_d;    // negate quotient at the end
   logic             rneg_q, rneg_d;    // negate remainder at the end
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_out_q, dbz_out_d;
   logic             done_q, done_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   trial;

   // Operand conditioning: magnitudes and signs of the incoming operands
   always_comb begin
      a_neg = 1'b0;
      b_neg = 1'b0;
`ifdef SEQ_DIVIDER32_SIGNED_EN
      a_neg = is_signed & dividend[WIDTH-1];
      b_neg = is_signed & divisor[WIDTH-1];
`endif
      a_abs = a_neg ? -dividend : dividend;
      b_abs = b_neg ? -divisor : divisor;
   end

   // Trial subtraction: shifted remainder minus divisor, borrow lands in the MSB
   always_comb begin
      trial = {rem_q, q_q[WIDTH-1]} - {1'b0, dvsr_q};
   end

   // Next-state, datapath and result logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      q_d         = q_q;
      dvsr_d      = dvsr_q;
      dbz_d       = dbz_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_out_d   = dbz_out_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dbz_out_d = 1'b0;
               dvsr_d    = b_abs;
               qneg_d    = a_neg ^ b_neg;
               rneg_d    = a_neg;
               cnt_d     = CNT_W'(WIDTH);
               if (divisor == '0) begin
                  // Skip the iterations; raw dividend becomes the remainder
                  dbz_d   = 1'b1;
                  rem_d   = dividend;
                  q_d     = '0;
                  state_d = S_FINISH;
               end else begin
                  dbz_d   = 1'b0;
                  rem_d   = '0;
                  q_d     = a_abs;
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};
               q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FINISH;
            end
         end

         S_FINISH: begin
            done_d    = 1'b1;
            dbz_out_d = dbz_q;
            state_d   = S_IDLE;
            if (dbz_q) begin
               quotient_d  = '0;
               remainder_d = rem_q;
            end else begin
               quotient_d  = qneg_q ? -q_q : q_q;
               remainder_d = rneg_q ? -rem_q : rem_q;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         dvsr_q      <= '0;
         dbz_q       <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_out_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         q_q         <= q_d;
         dvsr_q      <= dvsr_d;
         dbz_q       <= dbz_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_out_q   <= dbz_out_d;
         done_q      <= done_d;
      end
   end

   assign busy        = (state_q == S_CALC);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: randomized operations against an
// arithmetic reference, latency/busy timing, handshake and reset abort.
module tb_seq_divider32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
`ifdef SEQ_DIVIDER32_SIGNED_EN
   logic        is_signed;
`endif

   int checks;
   int failures;

   seq_divider32 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
`ifdef SEQ_DIVIDER32_SIGNED_EN
      .is_signed   (is_signed),
`endif
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: ARM-style divide computed with plain arithmetic
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'd0;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Issue one operation (DUT must be idle) and follow it to its done pulse
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit sgn, input string name);
      logic [31:0] eq, er;
      int lat, got;
      ref_div(a, b, sgn, eq, er);
      lat = (b == 32'd0) ? 1 : 33;
      start = 1'b1; dividend = a; divisor = b;
`ifdef SEQ_DIVIDER32_SIGNED_EN
      is_signed = sgn;
`endif
      @(posedge clk); #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      checks++;
      if (busy !== (b != 32'd0)) begin
         failures++; $display("FAIL %s busy_after_accept: got %b expected %b", name, busy, (b != 32'd0));
      end
      checks++;
      if (div_by_zero !== 1'b0) begin
         failures++; $display("FAIL %s dbz_cleared: got %b expected 0", name, div_by_zero);
      end
      got = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            got = k;
            break;
         end
         checks++;
         if (busy !== (b != 32'd0 && k <= 31)) begin
            failures++; $display("FAIL %s busy_k%0d: got %b expected %b", name, k, busy, (b != 32'd0 && k <= 31));
         end
      end
      checks++;
      if (got != lat) begin
         failures++; $display("FAIL %s latency: got %0d expected %0d", name, got, lat);
      end
      checks++;
      if (quotient !== eq || remainder !== er) begin
         failures++; $display("FAIL %s result: got q=%h r=%h expected q=%h r=%h", name, quotient, remainder, eq, er);
      end
      checks++;
      if (div_by_zero !== (b == 32'd0) || busy !== 1'b0) begin
         failures++; $display("FAIL %s flags_at_done: got dbz=%b busy=%b expected dbz=%b busy=0", name, div_by_zero, busy, (b == 32'd0));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         failures++; $display("FAIL reset_ctrl: got busy=%b done=%b dbz=%b expected 0 0 0", busy, done, div_by_zero);
      end
      checks++;
      if (quotient !== 32'd0 || remainder !== 32'd0) begin
         failures++; $display("FAIL reset_data: got q=%h r=%h expected 0 0", quotient, remainder);
      end
      start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      do_op(32'd100, 32'd7, 1'b0, "u_100_7");
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (quotient !== 32'd14 || remainder !== 32'd2 || done !== 1'b0) begin
         failures++; $display("FAIL u_hold: got q=%h r=%h done=%b expected q=e r=2 done=0", quotient, remainder, done);
      end
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
      do_op(32'd5, 32'hFFFF_FFFF, 1'b0, "u_5_max");
      do_op(32'd3, 32'd3, 1'b0, "u_equal");
      do_op(32'd0, 32'd9, 1'b0, "u_zero_num");
   endtask

   task automatic test_div_by_zero();
      do_op(32'h1234_5678, 32'd0, 1'b0, "dbz_fixed");
      do_op(32'hDEAD_BEEF, 32'd0, 1'b0, "dbz_2");
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 16);
            2: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         do_op(a, b, 1'b0, "u_rand");
      end
   endtask

   task automatic test_back_to_back();
      do_op(32'd1000, 32'd10, 1'b0, "b2b_0");
      do_op(32'd77, 32'd0, 1'b0, "b2b_1");
      do_op(32'hABCD_0123, 32'd255, 1'b0, "b2b_2");
   endtask

   // start held high with changing operands: accepts at edges 0 and 34 only
   task automatic test_handshake();
      logic [31:0] oa [0:67];
      logic [31:0] ob [0:67];
      logic [31:0] eq, er;
      bit exp_done;
`ifdef SEQ_DIVIDER32_SIGNED_EN
      is_signed = 1'b0;
`endif
      for (int e = 0; e <= 67; e++) begin
         oa[e] = $urandom;
         ob[e] = $urandom_range(1, 5000);
         start = 1'b1; dividend = oa[e]; divisor = ob[e];
         @(posedge clk); #1;
         exp_done = (e == 33 || e == 67);
         checks++;
         if (done !== exp_done) begin
            failures++; $display("FAIL hs_done_e%0d: got %b expected %b", e, done, exp_done);
         end
         if (e == 33 || e == 67) begin
            ref_div(oa[e == 33 ? 0 : 34], ob[e == 33 ? 0 : 34], 1'b0, eq, er);
            checks++;
            if (quotient !== eq || remainder !== er) begin
               failures++; $display("FAIL hs_result_e%0d: got q=%h r=%h expected q=%h r=%h", e, quotient, remainder, eq, er);
            end
         end
         if (e == 34) begin
            checks++;
            if (busy !== 1'b1) begin
               failures++; $display("FAIL hs_second_accept: got busy=%b expected 1", busy);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int pulses;
      start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
         failures++; $display("FAIL midrst_outputs: got busy=%b done=%b q=%h r=%h dbz=%b expected all 0", busy, done, quotient, remainder, div_by_zero);
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses);
      end
      do_op(32'd9, 32'd2, 1'b0, "midrst_9_2");
   endtask

`ifdef SEQ_DIVIDER32_SIGNED_EN
   task automatic test_signed();
      logic [31:0] a, b;
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
      do_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s_7_m2");
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_m1");
      do_op(32'hFFFF_FFF9, 32'd0, 1'b1, "s_dbz");
      do_op(32'hFFFF_FFF9, 32'd2, 1'b0, "s_off");
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         do_op(a, b, $urandom_range(0, 1) == 1, "s_rand");
      end
   endtask
`endif

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef SEQ_DIVIDER32_SIGNED_EN
      is_signed = 1'b0;
`endif
      test_reset();
      test_unsigned();
      test_div_by_zero();
      test_back_to_back();
      test_random();
      test_handshake();
      test_reset_mid_op();
`ifdef SEQ_DIVIDER32_SIGNED_EN
      test_signed();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
